// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, register index
// width and the saturating-increment helper used by the performance counters.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard check of the ID operands against in-flight producers.
// With forwarding active only a load in EXE can still cause a stall.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 fwd_en,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  output logic                 hazard
);

  logic exe_prod;
  logic mem_prod;
  logic match1;
  logic match2;

  // The forwarding unit covers every producer except a load whose data is not back yet.
  assign exe_prod = exe_wb_en && (!fwd_en || exe_mem_r_en);
  assign mem_prod = mem_wb_en && !fwd_en;

  assign match1 = (exe_prod && (id_src1 == exe_dest)) || (mem_prod && (id_src1 == mem_dest));
  assign match2 = id_two_src &&
                  ((exe_prod && (id_src2 == exe_dest)) || (mem_prod && (id_src2 == mem_dest)));

  assign hazard = id_valid && (match1 || match2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Drives freeze/flush pins of the 5-stage pipe registers: memory-wait freeze, branch flush,
// RAW bubble insertion (all combinational), plus registered saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fwd_en,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic                 exe_b,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 mem_req,
  output logic                 freeze_pc,
  output logic                 freeze_if_id,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 freeze_exe,
  output logic                 freeze_mem,
  output logic                 mem_done,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int              WCW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0]  WAIT_LOAD = WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [31:0]     CNT_MAX   = 32'({CNT_W{1'b1}});

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic mem_frz;
  logic mem_done_raw;
  logic stall_ev;
  logic flush_ev;

  hazard_detect u_hazard_detect (
    .fwd_en       (fwd_en),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_frz      = 1'b0;
    mem_done_raw = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req) begin
          if (WAIT_CYCLES > 0) begin
            mem_frz    = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            mem_done_raw = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        mem_frz = 1'b1;
        if (wait_cnt_q == '0) begin
          state_d = MEM_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - WCW'(1);
        end
      end
      // mem_req is still high here for the same access; ignore it so it is not replayed.
      MEM_DONE: begin
        mem_done_raw = 1'b1;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign flush_ev = !mem_frz && exe_b;
  assign stall_ev = mem_frz || (hazard && !exe_b);

  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    freeze_exe   = 1'b0;
    freeze_mem   = 1'b0;
    mem_done     = 1'b0;
    if (!rst) begin
      mem_done = mem_done_raw;
      if (mem_frz) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        freeze_exe   = 1'b1;
        freeze_mem   = 1'b1;
      end else if (exe_b) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (hazard) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        flush_id_ex  = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev) stall_cnt_d = CNT_W'(sat_inc(32'(stall_cnt_q), CNT_MAX));
    if (flush_ev) flush_cnt_d = CNT_W'(sat_inc(32'(flush_cnt_q), CNT_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
